// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with arbitrary depth, programmable almost flags,
// occupancy count, standard or first-word-fall-through read, and synchronous flush.
module fifo_sync_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              wr_en,
    input  logic [FIFO_WIDTH-1:0]             data_in,
    input  logic                              rd_en,
    output logic [FIFO_WIDTH-1:0]             data_out,
    output logic                              rd_valid,
    output logic                              full,
    output logic                              almostfull,
    output logic                              empty,
    output logic                              almostempty,
    output logic                              wr_ack,
    output logic                              overflow,
    output logic                              underflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // A read on a full FIFO frees a slot in the same cycle, so the write may proceed.
    assign rd_acc = rd_en & (count != '0);
    assign wr_acc = wr_en & ((count != DEPTH_C) | rd_acc);

    assign full        = (count == DEPTH_C);
    assign almostfull  = (count >= AF_C);
    assign empty       = (count == '0);
    assign almostempty = (count <= AE_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            wr_ack    <= wr_acc;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !clear) mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out <= '0;
                    rd_valid <= 1'b0;
                end else if (clear) begin
                    rd_valid <= 1'b0;
                end else if (rd_acc) begin
                    data_out <= mem[rd_ptr];
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's 16x8 FIFO.
- Adds:
  - arbitrary (non-power-of-2) depth
  - programmable almost-full/almost-empty thresholds
  - occupancy count output
  - selectable standard or first-word-fall-through (FWFT) read mode
  - synchronous flush
  - read-while-full acceptance
- Sits between a producer and a consumer in one clock domain; same flag set as the existing FIFO, so existing checkers reuse.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries (>=2, need not be a power of 2).
- AF_THRESH, FIFO_DEPTH-1, almostfull asserted when count >= AF_THRESH (1..FIFO_DEPTH).
- AE_THRESH, 1, almostempty asserted when count <= AE_THRESH (0..FIFO_DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush; empties the FIFO.
- wr_en  input  1  write request.
- data_in  input  FIFO_WIDTH  write data.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  read data.
- rd_valid  output  1  data_out holds valid read data.
- full  output  1  count == FIFO_DEPTH.
- almostfull  output  1  count >= AF_THRESH.
- empty  output  1  count == 0.
- almostempty  output  1  count <= AE_THRESH.
- wr_ack  output  1  registered pulse: previous-cycle write accepted.
- overflow  output  1  registered pulse: previous-cycle write rejected.
- underflow  output  1  registered pulse: previous-cycle read rejected.
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0; rd_valid, wr_ack, overflow, underflow = 0.
  - empty = 1, almostempty = 1, full = 0, almostfull = 0.
  - Memory contents are not reset.
  - Reset mid-burst discards all contents immediately.
- Acceptance, evaluated on the current-cycle count:
  - rd_acc = rd_en & (count != 0).
  - wr_acc = wr_en & ((count != FIFO_DEPTH) | rd_acc). When full, a simultaneous read makes room, so the write is accepted.
  - When empty with wr_en and rd_en together: write accepted, read rejected (underflow). This holds in both modes.
- Count update:
  - count += wr_acc - rd_acc.
  - Simultaneous accepted read and write leave count unchanged.
- Pointers:
  - Increment on acceptance.
  - Wrap from FIFO_DEPTH-1 to 0; no power-of-2 assumption.
- Flags:
  - full, almostfull, empty and almostempty are combinational decodes of the registered count.
  - They change the cycle after the causing edge and have no extra latency.
- Status pulses (registered, one cycle each):
  - wr_ack = wr_acc.
  - overflow = wr_en & ~wr_acc.
  - underflow = rd_en & ~rd_acc.
  - wr_ack and overflow are mutually exclusive.
- FWFT=0 (standard read):
  - On rd_acc, data_out <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and data_out holds its last value.
  - Read latency is 1 cycle from the rd_en edge.
- FWFT=1 (fall-through read):
  - data_out = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en pops the shown word.
  - First written word appears on data_out the cycle after its write edge, which is the same cycle empty deasserts.
  - While empty, data_out value is don't-care.
- clear = 1 (takes priority over wr_en and rd_en):
  - Pointers and count go to 0.
  - wr_ack and rd_valid (FWFT=0) go to 0.
  - No overflow or underflow is flagged.
  - data_out holds in FWFT=0.
- Data integrity: words leave in exact write order across any number of pointer wraps.

Test Plan:
- Defaults (16x8, AF=7, AE=1, FWFT=0); write 0x0001..0x0008, then a 9th write of 0xFFFF -> wr_ack pulses 8 times; full=1, count=8; next cycle overflow=1, wr_ack=0; almostfull first seen when count=7.
- From full: wr_en=rd_en=1 with data_in 0xAAAA for 1 cycle -> wr_ack=1, no overflow; count stays 8; data_out=0x0001 with rd_valid=1 one cycle later; 0xAAAA is read out last.
- Empty FIFO: rd_en=1 -> underflow=1 next cycle, count=0; rd_en=wr_en=1 with 0x1234 -> count=1, underflow=1, wr_ack=1.
- FIFO_DEPTH=5, FWFT=1: 12 interleaved writes/reads of 0x0000..0x000B -> data_out shows each head with rd_valid=1 before rd_en; order is preserved across wrap; empty deasserts the cycle after the first write.
- Partially filled (count=4): clear=1 alongside wr_en=1 -> count=0, empty=1, almostempty=1, wr_ack=0, overflow=0.
- Count=3 mid-burst: assert rst asynchronously between edges -> all outputs are at reset values immediately; after release, first read underflows.
